// File: rtl/gpioemu_mulpop_if.sv
// ----------------------------------------------------------------------------
// gpioemu_mulpop_if : CPU-side register bus for the multiply/popcount block
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface gpioemu_mulpop_if #(
  parameter int DATA_W = 32
);
  logic [15:0]       saddress;
  logic              srd;
  logic              swr;
  logic [DATA_W-1:0] sdata_in;
  logic [DATA_W-1:0] sdata_out;

  modport master (
    output saddress,
    output srd,
    output swr,
    output sdata_in,
    input  sdata_out
  );

  modport slave (
    input  saddress,
    input  srd,
    input  swr,
    input  sdata_in,
    output sdata_out
  );
endinterface

`default_nettype wire

// File: rtl/gpioemu_mulpop.sv
// ----------------------------------------------------------------------------
// gpioemu_mulpop : bus-mapped shift-add multiplier with popcount of the low word
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gpioemu_mulpop #(
  parameter int          OP_W      = 24,
  parameter int          DATA_W    = 32,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0380
) (
  input  logic                 clk,
  input  logic                 n_reset,
  gpioemu_mulpop_if.slave      bus,
  input  logic [31:0]          gpio_in,
  input  logic                 gpio_latch,
  output logic [31:0]          gpio_out,
  output logic [31:0]          gpio_in_s_insp
);

  localparam int PROD_W = 2 * OP_W;
  // Wide enough that both the low word and a full DATA_W high slice always exist.
  localparam int EXT_W  = (PROD_W > 2 * DATA_W) ? PROD_W : 2 * DATA_W;
  localparam int PC_W   = $clog2(DATA_W + 1);
  localparam int BC_W   = $clog2(OP_W + 1);

  localparam logic [15:0] ADDR_A1   = BASE_ADDR;
  localparam logic [15:0] ADDR_A2   = BASE_ADDR + 16'h0008;
  localparam logic [15:0] ADDR_W    = BASE_ADDR + 16'h0010;
  localparam logic [15:0] ADDR_L    = BASE_ADDR + 16'h0018;
  localparam logic [15:0] ADDR_CTRL = BASE_ADDR + 16'h0020;
  localparam logic [15:0] ADDR_HI   = BASE_ADDR + 16'h0028;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_POP  = 2'd2
  } state_e;

  state_e             state_q,       state_d;
  logic               srd_q,         srd_prev_q;
  logic               swr_q,         swr_prev_q;
  logic               gl_q,          gl_prev_q;
  logic [15:0]        addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [31:0]        gpio_q;
  logic [OP_W-1:0]    a1_q,          a1_d;
  logic [OP_W-1:0]    a2_q,          a2_d;
  logic [PROD_W-1:0]  mcand_q,       mcand_d;
  logic [OP_W-1:0]    mplier_q,      mplier_d;
  logic [PROD_W-1:0]  acc_q,         acc_d;
  logic [BC_W-1:0]    bit_cnt_q,     bit_cnt_d;
  logic [DATA_W-1:0]  w_q,           w_d;
  logic [PC_W-1:0]    l_q,           l_d;
  logic [DATA_W-1:0]  hi_q,          hi_d;
  logic               ready_q,       ready_d;
  logic               valid_q,       valid_d;
  logic [CNT_W-1:0]   op_count_q,    op_count_d;
  logic [DATA_W-1:0]  sdata_out_q,   sdata_out_d;
  logic [31:0]        insp_q,        insp_d;

  logic               rd_ev, wr_ev, gl_ev;
  logic               sel_a1, sel_a2, sel_w, sel_l, sel_ctrl, sel_hi;
  logic [DATA_W-1:0]  rdata;
  logic [EXT_W-1:0]   prod_ext;
  logic [DATA_W-1:0]  prod_lo;
  logic [DATA_W-1:0]  prod_hi;
  logic               prod_over;
  logic [PC_W-1:0]    prod_pop;
  logic               unused_wdata;

  function automatic logic [PC_W-1:0] popcnt(input logic [DATA_W-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  // A strobe counts once: it must be seen high after having been seen low.
  assign rd_ev = srd_q & ~srd_prev_q;
  assign wr_ev = swr_q & ~swr_prev_q;
  assign gl_ev = gl_q  & ~gl_prev_q;

  assign sel_a1   = (addr_q == ADDR_A1);
  assign sel_a2   = (addr_q == ADDR_A2);
  assign sel_w    = (addr_q == ADDR_W);
  assign sel_l    = (addr_q == ADDR_L);
  assign sel_ctrl = (addr_q == ADDR_CTRL);
  assign sel_hi   = (addr_q == ADDR_HI);

  assign prod_ext  = EXT_W'(acc_q);
  assign prod_lo   = prod_ext[DATA_W-1:0];
  assign prod_hi   = prod_ext[2*DATA_W-1:DATA_W];
  assign prod_over = |(prod_ext >> DATA_W);
  assign prod_pop  = popcnt(prod_lo);

  // Operand writes keep only OP_W bits and CTRL write data is a pure trigger.
  assign unused_wdata = ^wdata_q;

  always_comb begin
    rdata = '0;
    if (sel_w) begin
      rdata = w_q;
    end else if (sel_l) begin
      rdata = DATA_W'(l_q);
    end else if (sel_ctrl) begin
      rdata = DATA_W'({ready_q, valid_q});
    end else if (sel_hi) begin
      rdata = hi_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    w_d         = w_q;
    l_d         = l_q;
    hi_d        = hi_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    op_count_d  = op_count_q;
    sdata_out_d = sdata_out_q;
    insp_d      = insp_q;

    // Read mux uses current register values, so a same-cycle write is not visible.
    if (rd_ev) begin
      sdata_out_d = rdata;
    end
    if (gl_ev) begin
      insp_d = gpio_q;
    end
    if (wr_ev && sel_a1) begin
      a1_d = wdata_q[OP_W-1:0];
    end
    if (wr_ev && sel_a2) begin
      a2_d = wdata_q[OP_W-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (wr_ev && sel_ctrl) begin
          mcand_d   = PROD_W'(a1_q);
          mplier_d  = a2_q;
          acc_d     = '0;
          bit_cnt_d = '0;
          ready_d   = 1'b0;
          valid_d   = 1'b1;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (bit_cnt_q == BC_W'(OP_W - 1)) begin
          state_d = S_POP;
        end
      end
      S_POP: begin
        w_d        = prod_lo;
        hi_d       = prod_hi;
        l_d        = prod_pop;
        valid_d    = ~prod_over;
        ready_d    = 1'b1;
        op_count_d = op_count_q + CNT_W'(1);
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      srd_q       <= 1'b0;
      srd_prev_q  <= 1'b0;
      swr_q       <= 1'b0;
      swr_prev_q  <= 1'b0;
      gl_q        <= 1'b0;
      gl_prev_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gpio_q      <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      w_q         <= '0;
      l_q         <= '0;
      hi_q        <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b1;
      op_count_q  <= '0;
      sdata_out_q <= '0;
      insp_q      <= '0;
    end else begin
      state_q     <= state_d;
      srd_q       <= bus.srd;
      srd_prev_q  <= srd_q;
      swr_q       <= bus.swr;
      swr_prev_q  <= swr_q;
      gl_q        <= gpio_latch;
      gl_prev_q   <= gl_q;
      addr_q      <= bus.saddress;
      wdata_q     <= bus.sdata_in;
      gpio_q      <= gpio_in;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      w_q         <= w_d;
      l_q         <= l_d;
      hi_q        <= hi_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      op_count_q  <= op_count_d;
      sdata_out_q <= sdata_out_d;
      insp_q      <= insp_d;
    end
  end

  assign bus.sdata_out  = sdata_out_q;
  assign gpio_out       = 32'(op_count_q);
  assign gpio_in_s_insp = insp_q;

endmodule

`default_nettype wire
